byte_ram_ctrl: RTL and testbench

- Parametrised, byte-addressed, little-endian data memory with a request/done handshake.
- Supports byte, halfword and word accesses, with sign or zero extension on loads.
- Flags misaligned, reserved-size and out-of-range accesses.
- Sits between the CPU load/store stage and local memory; replaces the fixed 64 KiB word-only RAM.

---
 rtl/byte_ram_ctrl.sv | 157 +++++++++++++++
 tb/tb_byte_ram_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_ram_ctrl.sv
// rtl/byte_ram_ctrl.sv - byte-addressed little-endian data memory with req/done handshake
module byte_ram_ctrl #(
    parameter int ADDR_W    = 16,
    parameter int MEM_BYTES = 65536,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              wen,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       in,
    output logic [31:0]       out,
    output logic              done,
    output logic              err,
    output logic              busy
);

    localparam int          IDX_W   = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam logic [32:0] MEM_LIM = 33'(MEM_BYTES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state;

    // Request fields captured in IDLE; later input changes cannot disturb an access.
    logic              a_wen;
    logic [1:0]        a_size;
    logic              a_uns;
    logic [ADDR_W-1:0] a_addr;
    logic [31:0]       a_data;

    logic [7:0] mem [0:MEM_BYTES-1];

    logic [1:0]       span;
    logic             misalign;
    logic [32:0]      last_addr;
    logic             oor;
    logic             acc_err;
    logic [IDX_W-1:0] idx0;
    logic [IDX_W-1:0] idx1;
    logic [IDX_W-1:0] idx2;
    logic [IDX_W-1:0] idx3;
    logic [7:0]       rd_b0;
    logic [7:0]       rd_b1;
    logic [7:0]       rd_b2;
    logic [7:0]       rd_b3;
    logic [31:0]      load_val;

    // Classify the captured access: alignment, reserved size and range of its last byte.
    always_comb begin
        span = 2'd0;
        case (a_size)
            2'b00:   span = 2'd0;
            2'b01:   span = 2'd1;
            default: span = 2'd3;
        endcase
        misalign  = ((a_size == 2'b01) && a_addr[0]) ||
                    ((a_size == 2'b10) && (a_addr[1:0] != 2'b00));
        last_addr = 33'(a_addr) + 33'(span);
        oor       = (last_addr >= MEM_LIM);
        acc_err   = (a_size == 2'b11) || misalign || oor;
    end

    // Byte lane indices; only meaningful when the access is in range, otherwise out is forced to 0.
    always_comb begin
        idx0  = a_addr[IDX_W-1:0];
        idx1  = idx0 + IDX_W'(1);
        idx2  = idx0 + IDX_W'(2);
        idx3  = idx0 + IDX_W'(3);
        rd_b0 = mem[idx0];
        rd_b1 = mem[idx1];
        rd_b2 = mem[idx2];
        rd_b3 = mem[idx3];
    end

    // Assemble the load result with sign or zero extension by access size.
    always_comb begin
        load_val = 32'd0;
        case (a_size)
            2'b00:   load_val = {{24{~a_uns & rd_b0[7]}}, rd_b0};
            2'b01:   load_val = {{16{~a_uns & rd_b1[7]}}, rd_b1, rd_b0};
            default: load_val = {rd_b3, rd_b2, rd_b1, rd_b0};
        endcase
    end

    // Store on the edge leaving ACCESS; an asynchronous reset already forced IDLE, so an aborted store writes nothing.
    always_ff @(posedge clk) begin
        if (state == ACCESS && a_wen && !acc_err) begin
            mem[idx0] <= a_data[7:0];
            if (a_size != 2'b00) begin
                mem[idx1] <= a_data[15:8];
            end
            if (a_size == 2'b10) begin
                mem[idx2] <= a_data[23:16];
                mem[idx3] <= a_data[31:24];
            end
        end
    end

    // Control FSM with registered outputs: capture, execute, then pulse done as busy drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            out    <= 32'd0;
            done   <= 1'b0;
            err    <= 1'b0;
            busy   <= 1'b0;
            a_wen  <= 1'b0;
            a_size <= 2'b00;
            a_uns  <= 1'b0;
            a_addr <= '0;
            a_data <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    if (req) begin
                        a_wen  <= wen;
                        a_size <= size;
                        a_uns  <= uns;
                        a_addr <= addr;
                        a_data <= in;
                        busy   <= 1'b1;
                        state  <= ACCESS;
                    end
                end
                ACCESS: begin
                    state <= RESP;
                    if (acc_err) begin
                        out <= 32'd0;
                    end else if (!a_wen) begin
                        out <= load_val;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    err   <= acc_err;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_ram_ctrl.sv
// tb/tb_byte_ram_ctrl.sv - self-checking bench for byte_ram_ctrl with a byte-array reference model
module tb_byte_ram_ctrl;

    localparam int MEMB = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        wen;
    logic [1:0]  size;
    logic        uns;
    logic [15:0] addr;
    logic [31:0] din;
    logic [31:0] out;
    logic        done;
    logic        err;
    logic        busy;

    always #5 clk = ~clk;

    byte_ram_ctrl #(
        .ADDR_W   (16),
        .MEM_BYTES(MEMB),
        .INIT_FILE("")
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .wen  (wen),
        .size (size),
        .uns  (uns),
        .addr (addr),
        .in   (din),
        .out  (out),
        .done (done),
        .err  (err),
        .busy (busy)
    );

    int          n_pass = 0;
    int          n_total = 0;
    logic [7:0]  model [0:MEMB-1];
    logic [31:0] exp_out = 32'd0;
    logic        exp_err = 1'b0;

    function automatic logic ref_err(input logic [1:0] sz, input int a);
        int n;
        if (sz == 2'b11) return 1'b1;
        n = 1 << sz;
        if ((a % n) != 0) return 1'b1;
        if (a + n > MEMB) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_access(input logic w, input logic [1:0] sz, input logic u,
                                input int a, input logic [31:0] d);
        int n;
        logic [31:0] v;
        exp_err = ref_err(sz, a);
        if (exp_err) begin
            exp_out = 32'd0;
            return;
        end
        n = 1 << sz;
        if (w) begin
            for (int i = 0; i < n; i++) model[a + i] = d[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = model[a + i];
            if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            exp_out = v;
        end
    endtask

    // Starts at a negedge, returns at the negedge where done is seen (lat = negedges waited, -1 on timeout).
    task automatic do_access(input logic w, input logic [1:0] sz, input logic u,
                             input int a, input logic [31:0] d, output int lat);
        req  = 1'b1;
        wen  = w;
        size = sz;
        uns  = u;
        addr = a[15:0];
        din  = d;
        @(posedge clk);
        #1;
        req  = 1'b0;
        wen  = 1'($urandom);
        size = 2'($urandom);
        uns  = 1'($urandom);
        addr = 16'($urandom);
        din  = $urandom;
        lat  = -1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
        end
        model_access(w, sz, u, a, d);
    endtask

    task automatic test_reset();
        int lat;
        rst_n = 1'b0;
        req   = 1'b1;
        wen   = 1'b1;
        size  = 2'b10;
        uns   = 1'b0;
        addr  = 16'h0000;
        din   = 32'h0BAD_F00D;
        repeat (3) @(negedge clk);
        n_total++; if (out !== 32'd0) $display("FAIL reset_out got %h expected %h", out, 32'd0); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done got %b expected 0", done); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b expected 0", busy); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL reset_err got %b expected 0", err); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_total++; if (busy !== 1'b1) $display("FAIL reset_first_capture busy got %b expected 1", busy); else n_pass++;
        req = 1'b0;
        lat = -1;
        for (int c = 2; c <= 8; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
        end
        model_access(1'b1, 2'b10, 1'b0, 0, 32'h0BAD_F00D);
        n_total++; if (lat !== 3) $display("FAIL reset_release_latency got %0d expected 3", lat); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL reset_release_err got %b expected 0", err); else n_pass++;
    endtask

    task automatic test_prefill();
        int lat;
        int bad = 0;
        for (int w = 0; w < MEMB / 4; w++) begin
            do_access(1'b1, 2'b10, 1'b0, w * 4, $urandom, lat);
            if (lat != 3 || err !== 1'b0) bad++;
        end
        n_total++; if (bad !== 0) $display("FAIL prefill_stores bad %0d expected 0", bad); else n_pass++;
    endtask

    task automatic test_word();
        int lat;
        do_access(1'b1, 2'b10, 1'b0, 'h10, 32'hDEAD_BEEF, lat);
        n_total++; if (lat !== 3 || err !== 1'b0) $display("FAIL word_store lat %0d err %b expected 3 0", lat, err); else n_pass++;
        do_access(1'b0, 2'b10, 1'b0, 'h10, 32'd0, lat);
        n_total++; if (lat !== 3 || err !== 1'b0) $display("FAIL word_load lat %0d err %b expected 3 0", lat, err); else n_pass++;
        n_total++; if (out !== 32'hDEAD_BEEF) $display("FAIL word_load_data got %h expected %h", out, 32'hDEAD_BEEF); else n_pass++;
    endtask

    task automatic test_byte_ext();
        int lat;
        logic [31:0] want;
        do_access(1'b1, 2'b00, 1'b0, 'h21, 32'h0000_0080, lat);
        n_total++; if (err !== 1'b0) $display("FAIL byte_store err got %b expected 0", err); else n_pass++;
        do_access(1'b0, 2'b00, 1'b0, 'h21, 32'd0, lat);
        n_total++; if (out !== 32'hFFFF_FF80) $display("FAIL byte_load_signed got %h expected %h", out, 32'hFFFF_FF80); else n_pass++;
        do_access(1'b0, 2'b00, 1'b1, 'h21, 32'd0, lat);
        n_total++; if (out !== 32'h0000_0080) $display("FAIL byte_load_unsigned got %h expected %h", out, 32'h0000_0080); else n_pass++;
        want = {16'hFFFF, 8'h80, model['h20]};
        do_access(1'b0, 2'b01, 1'b0, 'h20, 32'd0, lat);
        n_total++; if (out !== want) $display("FAIL half_load_signed got %h expected %h", out, want); else n_pass++;
    endtask

    task automatic test_misaligned();
        int lat;
        do_access(1'b1, 2'b10, 1'b0, 'h13, 32'h5555_AAAA, lat);
        n_total++; if (lat !== 3 || err !== 1'b1) $display("FAIL misaligned_word_store lat %0d err %b expected 3 1", lat, err); else n_pass++;
        do_access(1'b0, 2'b10, 1'b0, 'h10, 32'd0, lat);
        n_total++; if (out !== 32'hDEAD_BEEF) $display("FAIL misaligned_readback_10 got %h expected %h", out, 32'hDEAD_BEEF); else n_pass++;
        do_access(1'b0, 2'b10, 1'b0, 'h14, 32'd0, lat);
        n_total++; if (out !== exp_out) $display("FAIL misaligned_readback_14 got %h expected %h", out, exp_out); else n_pass++;
        do_access(1'b0, 2'b01, 1'b0, 'h01, 32'd0, lat);
        n_total++; if (err !== 1'b1 || out !== 32'd0) $display("FAIL misaligned_half_load err %b out %h expected 1 0", err, out); else n_pass++;
        do_access(1'b0, 2'b11, 1'b0, 'h08, 32'd0, lat);
        n_total++; if (lat !== 3 || err !== 1'b1) $display("FAIL reserved_size lat %0d err %b expected 3 1", lat, err); else n_pass++;
    endtask

    task automatic test_range();
        int lat;
        do_access(1'b0, 2'b10, 1'b0, 'h3FC, 32'd0, lat);
        n_total++; if (err !== 1'b0 || out !== exp_out) $display("FAIL top_word_load err %b out %h expected 0 %h", err, out, exp_out); else n_pass++;
        do_access(1'b0, 2'b10, 1'b0, 'h400, 32'd0, lat);
        n_total++; if (err !== 1'b1 || out !== 32'd0) $display("FAIL oor_word_load err %b out %h expected 1 0", err, out); else n_pass++;
        do_access(1'b0, 2'b10, 1'b0, 'h3FC, 32'd0, lat);
        do_access(1'b1, 2'b00, 1'b0, 'hFFFF, 32'h0000_00C3, lat);
        n_total++; if (err !== 1'b1 || out !== 32'd0) $display("FAIL oor_byte_store err %b out %h expected 1 0", err, out); else n_pass++;
        do_access(1'b0, 2'b00, 1'b1, 'h3FF, 32'd0, lat);
        n_total++; if (out !== exp_out) $display("FAIL oor_no_write got %h expected %h", out, exp_out); else n_pass++;
    endtask

    task automatic test_busy_ignore();
        int lat;
        int ndone = 0;
        req  = 1'b1;
        wen  = 1'b1;
        size = 2'b10;
        uns  = 1'b0;
        addr = 16'h0048;
        din  = 32'hCAFE_0001;
        @(posedge clk);
        #1;
        addr = 16'h0044;
        din  = 32'hA5A5_A5A5;
        @(negedge clk);
        ndone += int'(done);
        n_total++; if (busy !== 1'b1) $display("FAIL busy_high got %b expected 1", busy); else n_pass++;
        @(posedge clk);
        @(negedge clk);
        ndone += int'(done);
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (5) begin
            @(negedge clk);
            ndone += int'(done);
        end
        model_access(1'b1, 2'b10, 1'b0, 'h48, 32'hCAFE_0001);
        n_total++; if (ndone !== 1) $display("FAIL busy_single_done got %0d expected 1", ndone); else n_pass++;
        do_access(1'b0, 2'b10, 1'b0, 'h44, 32'd0, lat);
        n_total++; if (out !== exp_out) $display("FAIL busy_ignored_store got %h expected %h", out, exp_out); else n_pass++;
        do_access(1'b0, 2'b10, 1'b0, 'h48, 32'd0, lat);
        n_total++; if (out !== 32'hCAFE_0001) $display("FAIL busy_captured_store got %h expected %h", out, 32'hCAFE_0001); else n_pass++;
    endtask

    task automatic test_reset_access();
        int lat;
        req  = 1'b1;
        wen  = 1'b1;
        size = 2'b10;
        uns  = 1'b0;
        addr = 16'h0040;
        din  = 32'h1122_3344;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_total++; if (busy !== 1'b0 || done !== 1'b0 || out !== 32'd0)
            $display("FAIL mid_reset_outputs busy %b done %b out %h expected 0 0 0", busy, done, out); else n_pass++;
        exp_out = 32'd0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_access(1'b0, 2'b10, 1'b0, 'h40, 32'd0, lat);
        n_total++; if (lat !== 3 || out !== exp_out) $display("FAIL mid_reset_no_write lat %0d out %h expected 3 %h", lat, out, exp_out); else n_pass++;
    endtask

    task automatic test_random();
        int lat;
        int a;
        logic [1:0] sz;
        logic w;
        logic u;
        logic [31:0] d;
        for (int k = 0; k < 300; k++) begin
            sz = 2'($urandom);
            w  = 1'($urandom);
            u  = 1'($urandom);
            d  = $urandom;
            if ($urandom_range(0, 9) == 0) a = $urandom_range(0, 65535);
            else a = $urandom_range(0, MEMB + 8);
            if ($urandom_range(0, 9) < 7 && sz != 2'b11) a = a & ~((1 << sz) - 1);
            do_access(w, sz, u, a, d, lat);
            n_total++; if (lat !== 3) $display("FAIL rand_latency #%0d got %0d expected 3", k, lat); else n_pass++;
            n_total++; if (err !== exp_err) $display("FAIL rand_err #%0d a %h sz %0d got %b expected %b", k, a, sz, err, exp_err); else n_pass++;
            n_total++; if (out !== exp_out) $display("FAIL rand_out #%0d a %h sz %0d got %h expected %h", k, a, sz, out, exp_out); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_prefill();
        test_word();
        test_byte_ext();
        test_misaligned();
        test_range();
        test_busy_ignore();
        test_reset_access();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
